rpn_exec_unit: RTL and testbench
================================

Name: rpn_exec_unit

Overview:
Parametrised command/arithmetic engine for the RPN calculator. It sits between the numpad decoder and the stack.
- Turns each new key code into exactly one stack command (write, push, pop+write), with the computed value.
- Adds key edge detection, a multi-cycle signed divider with busy, stack-underflow checks, and error flags.

Parameters:
WIDTH, 32, data width of stack values and arithmetic (>=8)
DEPTH_W, 6, width of stack element count input

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
key  in  5  numpad code; bit4=1 means a key is held; existing codebase encoding
top  in  WIDTH  stack top element
next  in  WIDTH  second stack element
count  in  DEPTH_W  stack element count
write  out  1  one-cycle pulse: overwrite top with value
push  out  1  one-cycle pulse: duplicate/push top
pop  out  1  one-cycle pulse: pop (always paired with write)
value  out  WIDTH  new top value, valid while write=1
busy  out  1  division in progress
err_div0  out  1  divide by zero
err_ovf  out  1  arithmetic overflow
err_under  out  1  binary op with count<2

Behaviour:
- Reset (reset=0 at a clock edge): write/push/pop/busy/all err_* = 0, value = 0, divider idle, key history cleared. A reset during a division aborts it; no pulse is issued.
- Key acceptance: a key is accepted in cycle N when key[4]=1, the registered previous key[4]=0, and busy=0.
  - Held keys never repeat.
  - Keys arriving while busy=1 are dropped, not queued.
  - top/next are latched at acceptance.
- Each accepted key clears all err_* flags in cycle N+1; otherwise flags are sticky.
- Non-divide commands: the single command pulse and value occur in cycle N+1. Pulses are exactly one cycle; value is held until the next command.
- Codes:
  - Digits: 10000=1, 10001=4, 10010=7, 10011=0, 10100=2, 10101=5, 10110=8, 11000=3, 11001=6, 11010=9.
    - Action: write; value = top*10 + d, mod 2^WIDTH.
    - err_ovf set if the true result exceeds 2^(WIDTH-1)-1 (signed).
  - 11100 (=): push only.
  - 11101 (+), 11110 (-), 11111 (*): pop+write; value = next op top, mod 2^WIDTH.
    - err_ovf on signed overflow; for *, this means the full 2*WIDTH product is not a sign-extension of the low WIDTH bits.
  - 10111 (neg): write; value = -top. err_ovf if top = most-negative value (result wraps to itself).
  - 11011 (/): signed divide next/top, truncating toward zero.
- Underflow: +, -, *, / with count<2 produce no pulse; err_under=1 in N+1.
- Division FSM (IDLE -> DIV -> DONE -> IDLE):
  - top=0: no pulse, err_div0=1 in N+1, FSM stays IDLE.
  - Otherwise busy=1 from N+1. A restoring unsigned divider on the magnitudes runs WIDTH iterations, one per cycle.
  - DONE in cycle N+1+WIDTH: pop+write pulse; value = quotient with sign = sign(next) XOR sign(top). busy=0 in that same cycle.
  - Most-negative / -1: value = most-negative; err_ovf=1.
  - Remainder discarded.
- Codes with bit4=1 not listed above: none exist. Bit4=0 means idle; no action.

Optional Feature:
HEX_ENTRY_EN
- Defined: adds input port entry_hex (1 bit), sampled at acceptance.
  - When 1, digit entry computes value = (top<<4) | d.
  - err_ovf is set if any of the top 4 bits of top are nonzero.
  - Other ops are unchanged.
- Undefined: port absent; entry is always decimal.

Test Plan:
- WIDTH=32, top=12, count=1, press "5" and hold 10 cycles -> single write pulse at N+1, value=125; no repeat while held.
- next=7, top=5, count=2, "-" -> pop=write=1 one cycle at N+1, value=2; "*" with next=0x7FFFFFFF, top=2 -> value=0xFFFFFFFE, err_ovf=1.
- next=-7, top=2, count=2, "/" -> busy for 32 cycles, pulse at N+33 with value=-3 (0xFFFFFFFD); a "+" pressed mid-division is ignored.
- "/" with top=0 -> no pulse, err_div0=1 at N+1; next accepted key clears it. "/" with next=0x80000000, top=-1 -> value=0x80000000, err_ovf=1.
- count=1, "+" -> no pulse, err_under=1. reset=0 during division -> busy=0 next cycle, no pulse ever issued.
- HEX_ENTRY_EN, entry_hex=1, top=0x1A, "9" -> value=0x1A9; top=0xF0000000, "1" -> err_ovf=1.

Source files
------------

// File: rtl/rpn_exec_unit_if.sv
// rpn_exec_unit_if: key/stack bus between the numpad/stack side (master)
// and the RPN execution unit (slave).
interface rpn_exec_unit_if #(
  parameter int WIDTH   = 32,
  parameter int DEPTH_W = 6
);
  logic [4:0]         key;
  logic [WIDTH-1:0]   top;
  logic [WIDTH-1:0]   next;
  logic [DEPTH_W-1:0] count;
  logic               write;
  logic               push;
  logic               pop;
  logic [WIDTH-1:0]   value;
  logic               busy;
  logic               err_div0;
  logic               err_ovf;
  logic               err_under;

  modport master (
    output key, top, next, count,
    input  write, push, pop, value, busy, err_div0, err_ovf, err_under
  );

  modport slave (
    input  key, top, next, count,
    output write, push, pop, value, busy, err_div0, err_ovf, err_under
  );
endinterface

// File: rtl/rpn_exec_unit.sv
// rpn_exec_unit: turns each newly pressed numpad key into one stack command
// (write, push, pop+write) with the computed value. Includes key edge
// detection, a multi-cycle restoring signed divider and sticky error flags.
// Optional build macro HEX_ENTRY_EN adds the entry_hex input, which switches
// digit entry from decimal (top*10+d) to hexadecimal ((top<<4)|d).
module rpn_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int DEPTH_W = 6
) (
  input  logic                clock,
  input  logic                reset,
`ifdef HEX_ENTRY_EN
  input  logic                entry_hex,
`endif
  rpn_exec_unit_if.slave      bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MINUS_ONE = '1;
  localparam logic signed [2*WIDTH-1:0] TEN     = (2*WIDTH)'(10);
  localparam logic signed [2*WIDTH-1:0] DEC_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t             state;
  logic               key_prev;
  logic               write_q, push_q, pop_q, busy_q;
  logic               err_div0_q, err_ovf_q, err_under_q;
  logic [WIDTH-1:0]   value_q;
  logic [WIDTH-1:0]   div_quo, div_rem, div_den;
  logic [CNT_W-1:0]   div_cnt;
  logic               div_neg, div_ovf;

  logic               accept, count_ok, hex_mode, is_digit;
  logic [3:0]         digit;
  logic signed [2*WIDTH-1:0] top_ext, next_ext, dec_wide, mul_wide;
  logic [WIDTH-1:0]   sum, diff, next_mag, top_mag;
  logic               add_ovf, sub_ovf, mul_ovf;
  logic               cmd_write, cmd_push, cmd_pop, cmd_ovf, cmd_under, cmd_div0, cmd_div;
  logic [WIDTH-1:0]   cmd_value;
  logic [WIDTH:0]     rem_shift, rem_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next, quo_next, quo_signed;

`ifdef HEX_ENTRY_EN
  assign hex_mode = entry_hex;
`else
  assign hex_mode = 1'b0;
`endif

  assign accept   = bus.key[4] & ~key_prev & ~busy_q;
  assign count_ok = (bus.count >= DEPTH_W'(2));

  assign top_ext  = {{WIDTH{bus.top[WIDTH-1]}}, bus.top};
  assign next_ext = {{WIDTH{bus.next[WIDTH-1]}}, bus.next};
  assign dec_wide = top_ext * TEN + $signed({{(2*WIDTH-4){1'b0}}, digit});
  assign mul_wide = next_ext * top_ext;
  assign sum      = bus.next + bus.top;
  assign diff     = bus.next - bus.top;
  assign add_ovf  = (bus.next[WIDTH-1] == bus.top[WIDTH-1]) && (sum[WIDTH-1] != bus.next[WIDTH-1]);
  assign sub_ovf  = (bus.next[WIDTH-1] != bus.top[WIDTH-1]) && (diff[WIDTH-1] != bus.next[WIDTH-1]);
  assign mul_ovf  = mul_wide[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){mul_wide[WIDTH-1]}};
  assign next_mag = bus.next[WIDTH-1] ? -bus.next : bus.next;
  assign top_mag  = bus.top[WIDTH-1] ? -bus.top : bus.top;

  assign rem_shift  = {div_rem, div_quo[WIDTH-1]};
  assign rem_diff   = rem_shift - {1'b0, div_den};
  assign q_bit      = ~rem_diff[WIDTH];
  assign rem_next   = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_next   = {div_quo[WIDTH-2:0], q_bit};
  assign quo_signed = div_neg ? -quo_next : quo_next;

  // Map the numpad key code to its digit value
  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (bus.key[3:0])
      4'b0000: digit = 4'd1;
      4'b0001: digit = 4'd4;
      4'b0010: digit = 4'd7;
      4'b0011: digit = 4'd0;
      4'b0100: digit = 4'd2;
      4'b0101: digit = 4'd5;
      4'b0110: digit = 4'd8;
      4'b1000: digit = 4'd3;
      4'b1001: digit = 4'd6;
      4'b1010: digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

  // Decide the command, result and error outcome for the current key
  always_comb begin
    cmd_write = 1'b0;
    cmd_push  = 1'b0;
    cmd_pop   = 1'b0;
    cmd_value = value_q;
    cmd_ovf   = 1'b0;
    cmd_under = 1'b0;
    cmd_div0  = 1'b0;
    cmd_div   = 1'b0;
    if (is_digit) begin
      cmd_write = 1'b1;
      if (hex_mode) begin
        cmd_value = {bus.top[WIDTH-5:0], digit};
        cmd_ovf   = |bus.top[WIDTH-1:WIDTH-4];
      end else begin
        cmd_value = dec_wide[WIDTH-1:0];
        cmd_ovf   = dec_wide > DEC_MAX;
      end
    end else begin
      case (bus.key[3:0])
        4'b0111: begin
          cmd_write = 1'b1;
          cmd_value = -bus.top;
          cmd_ovf   = (bus.top == MOST_NEG);
        end
        4'b1100: cmd_push = 1'b1;
        4'b1101, 4'b1110, 4'b1111: begin
          if (!count_ok) begin
            cmd_under = 1'b1;
          end else begin
            cmd_write = 1'b1;
            cmd_pop   = 1'b1;
            case (bus.key[1:0])
              2'b01:   begin cmd_value = sum;                  cmd_ovf = add_ovf; end
              2'b10:   begin cmd_value = diff;                 cmd_ovf = sub_ovf; end
              default: begin cmd_value = mul_wide[WIDTH-1:0];  cmd_ovf = mul_ovf; end
            endcase
          end
        end
        4'b1011: begin
          if (!count_ok)             cmd_under = 1'b1;
          else if (bus.top == '0)    cmd_div0  = 1'b1;
          else                       cmd_div   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Control FSM: key edge detection, command pulses, divider iterations and flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      key_prev    <= 1'b0;
      write_q     <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      busy_q      <= 1'b0;
      value_q     <= '0;
      err_div0_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_under_q <= 1'b0;
      div_quo     <= '0;
      div_rem     <= '0;
      div_den     <= '0;
      div_cnt     <= '0;
      div_neg     <= 1'b0;
      div_ovf     <= 1'b0;
    end else begin
      key_prev <= bus.key[4];
      write_q  <= 1'b0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      case (state)
        DIV: begin
          div_quo <= quo_next;
          div_rem <= rem_next;
          div_cnt <= div_cnt + CNT_W'(1);
          if (div_cnt == CNT_W'(WIDTH-1)) begin
            state   <= DONE;
            busy_q  <= 1'b0;
            write_q <= 1'b1;
            pop_q   <= 1'b1;
            value_q <= quo_signed;
            if (div_ovf) err_ovf_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          if (accept) begin
            write_q     <= cmd_write;
            push_q      <= cmd_push;
            pop_q       <= cmd_pop;
            err_ovf_q   <= cmd_ovf;
            err_under_q <= cmd_under;
            err_div0_q  <= cmd_div0;
            if (cmd_write) value_q <= cmd_value;
            if (cmd_div) begin
              state   <= DIV;
              busy_q  <= 1'b1;
              div_quo <= next_mag;
              div_rem <= '0;
              div_den <= top_mag;
              div_cnt <= '0;
              div_neg <= bus.next[WIDTH-1] ^ bus.top[WIDTH-1];
              div_ovf <= (bus.next == MOST_NEG) && (bus.top == MINUS_ONE);
            end
          end
        end
      endcase
    end
  end

  assign bus.write     = write_q;
  assign bus.push      = push_q;
  assign bus.pop       = pop_q;
  assign bus.value     = value_q;
  assign bus.busy      = busy_q;
  assign bus.err_div0  = err_div0_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_under = err_under_q;

endmodule

// File: tb/tb_rpn_exec_unit.sv
// tb_rpn_exec_unit: randomized self-checking bench for rpn_exec_unit with a
// behavioural reference model based on plain 64-bit integer arithmetic.
module tb_rpn_exec_unit;

  localparam int WIDTH   = 32;
  localparam int DEPTH_W = 6;
  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -64'sd2147483648;

  localparam logic [4:0] K0 = 5'b10011, K1 = 5'b10000, K2 = 5'b10100, K3 = 5'b11000;
  localparam logic [4:0] K4 = 5'b10001, K5 = 5'b10101, K6 = 5'b11001, K7 = 5'b10010;
  localparam logic [4:0] K8 = 5'b10110, K9 = 5'b11010;
  localparam logic [4:0] K_NEG = 5'b10111, K_EQ = 5'b11100, K_ADD = 5'b11101;
  localparam logic [4:0] K_SUB = 5'b11110, K_MUL = 5'b11111, K_DIV = 5'b11011;

  typedef struct packed {
    logic        w;
    logic        p;
    logic        pp;
    logic [31:0] v;
    logic        ovf;
    logic        under;
    logic        div0;
    logic        run;
  } exp_t;

  logic clock;
  logic reset;
`ifdef HEX_ENTRY_EN
  logic entry_hex;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m_value;
  logic        m_ovf, m_under, m_div0;
  logic [31:0] got;

  rpn_exec_unit_if #(.WIDTH(WIDTH), .DEPTH_W(DEPTH_W)) bus ();

  rpn_exec_unit #(.WIDTH(WIDTH), .DEPTH_W(DEPTH_W)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef HEX_ENTRY_EN
    .entry_hex (entry_hex),
`endif
    .bus       (bus)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: what one accepted key should do, from the command table
  function automatic exp_t ref_model(input logic [4:0] code, input logic [31:0] t,
                                     input logic [31:0] n, input int cnt, input logic hx);
    exp_t   e;
    longint st, sn, r;
    int     d;
    e  = '0;
    st = longint'($signed(t));
    sn = longint'($signed(n));
    d  = -1;
    case (code)
      K0: d = 0;  K1: d = 1;  K2: d = 2;  K3: d = 3;  K4: d = 4;
      K5: d = 5;  K6: d = 6;  K7: d = 7;  K8: d = 8;  K9: d = 9;
      default: d = -1;
    endcase
    if (d >= 0) begin
      e.w = 1'b1;
      if (hx) begin
        e.v   = (t << 4) | 32'(d);
        e.ovf = (t >> 28) != 32'd0;
      end else begin
        r     = st * 10 + longint'(d);
        e.v   = r[31:0];
        e.ovf = r > MAXL;
      end
    end else begin
      case (code)
        K_NEG: begin
          r     = -st;
          e.w   = 1'b1;
          e.v   = r[31:0];
          e.ovf = r > MAXL;
        end
        K_EQ: e.p = 1'b1;
        K_ADD, K_SUB, K_MUL: begin
          if (cnt < 2) e.under = 1'b1;
          else begin
            if (code == K_ADD)      r = sn + st;
            else if (code == K_SUB) r = sn - st;
            else                    r = sn * st;
            e.w   = 1'b1;
            e.pp  = 1'b1;
            e.v   = r[31:0];
            e.ovf = (r > MAXL) || (r < MINL);
          end
        end
        K_DIV: begin
          if (cnt < 2)        e.under = 1'b1;
          else if (st == 0)   e.div0  = 1'b1;
          else begin
            r     = sn / st;
            e.run = 1'b1;
            e.v   = r[31:0];
            e.ovf = r > MAXL;
          end
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  // Press one key, hold it, and check the whole response against the model
  task automatic applyStimulus(input logic [4:0] code, input logic [31:0] t, input logic [31:0] n,
                               input logic [5:0] cnt, input logic hx, input int hold,
                               input logic inject, output logic [31:0] observed);
    exp_t e;
    e = ref_model(code, t, n, int'(cnt), hx);
    bus.key   = code;
    bus.top   = t;
    bus.next  = n;
    bus.count = cnt;
`ifdef HEX_ENTRY_EN
    entry_hex = hx;
`endif
    @(negedge clock);
    if (e.run) begin
      m_ovf = 1'b0; m_under = 1'b0; m_div0 = 1'b0;
      checkOutput("div_start_flags", 64'({bus.err_ovf, bus.err_under, bus.err_div0}), 64'(3'b000));
      for (int c = 1; c <= WIDTH; c++) begin
        checkOutput("div_busy", 64'({bus.busy, bus.write, bus.push, bus.pop}), 64'(4'b1000));
        if (c >= hold) bus.key = 5'b0;
        if (inject && c == 8)  bus.key = K_ADD;
        if (inject && c == 11) bus.key = 5'b0;
        bus.top   = $urandom;
        bus.next  = $urandom;
        bus.count = 6'($urandom_range(0, 63));
        @(negedge clock);
      end
      m_value = e.v;
      m_ovf   = e.ovf;
      checkOutput("div_done_ctl", 64'({bus.busy, bus.write, bus.push, bus.pop}), 64'(4'b0101));
      checkOutput("div_value", 64'(bus.value), 64'(m_value));
      checkOutput("div_flags", 64'({bus.err_ovf, bus.err_under, bus.err_div0}), 64'({m_ovf, m_under, m_div0}));
      observed = bus.value;
    end else begin
      m_ovf   = e.ovf;
      m_under = e.under;
      m_div0  = e.div0;
      if (e.w) m_value = e.v;
      checkOutput("cmd_ctl", 64'({bus.busy, bus.write, bus.push, bus.pop}), 64'({1'b0, e.w, e.p, e.pp}));
      checkOutput("cmd_value", 64'(bus.value), 64'(m_value));
      checkOutput("cmd_flags", 64'({bus.err_ovf, bus.err_under, bus.err_div0}), 64'({m_ovf, m_under, m_div0}));
      observed = bus.value;
      for (int c = 2; c <= hold; c++) begin
        @(negedge clock);
        checkOutput("held_no_repeat", 64'({bus.write, bus.push, bus.pop}), 64'(3'b000));
      end
    end
    bus.key = 5'b0;
    @(negedge clock);
    checkOutput("idle_ctl", 64'({bus.busy, bus.write, bus.push, bus.pop}), 64'(4'b0000));
    checkOutput("idle_hold", 64'({bus.value, bus.err_ovf, bus.err_under, bus.err_div0}),
                64'({m_value, m_ovf, m_under, m_div0}));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 50));
      6: return -32'($urandom_range(1, 50));
      default: return $urandom;
    endcase
  endfunction

  // Main sequence: reset, directed scenarios, then randomized commands
  initial begin
    int          seen;
    logic [4:0]  code;
    logic [5:0]  cnt;
    logic        hx;
    reset     = 1'b0;
    bus.key   = 5'b0;
    bus.top   = '0;
    bus.next  = '0;
    bus.count = '0;
`ifdef HEX_ENTRY_EN
    entry_hex = 1'b0;
`endif
    m_value = '0; m_ovf = 1'b0; m_under = 1'b0; m_div0 = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset_ctl", 64'({bus.busy, bus.write, bus.push, bus.pop}), 64'(4'b0000));
    checkOutput("reset_flags", 64'({bus.err_ovf, bus.err_under, bus.err_div0}), 64'(3'b000));
    checkOutput("reset_value", 64'(bus.value), 64'(0));
    reset = 1'b1;

    applyStimulus(K5, 32'd12, 32'd0, 6'd1, 1'b0, 10, 1'b0, got);
    checkOutput("plan_digit", 64'(got), 64'(125));
    applyStimulus(K_SUB, 32'd5, 32'd7, 6'd2, 1'b0, 1, 1'b0, got);
    checkOutput("plan_sub", 64'(got), 64'(2));
    applyStimulus(K_MUL, 32'd2, 32'h7FFF_FFFF, 6'd2, 1'b0, 1, 1'b0, got);
    checkOutput("plan_mul", 64'({got, bus.err_ovf}), 64'({32'hFFFF_FFFE, 1'b1}));
    applyStimulus(K_DIV, 32'd2, -32'd7, 6'd2, 1'b0, 1, 1'b1, got);
    checkOutput("plan_div", 64'(got), 64'(32'hFFFF_FFFD));
    applyStimulus(K_DIV, 32'd0, 32'd5, 6'd3, 1'b0, 1, 1'b0, got);
    checkOutput("plan_div0", 64'(bus.err_div0), 64'(1));
    applyStimulus(K_EQ, 32'd4, 32'd5, 6'd3, 1'b0, 1, 1'b0, got);
    checkOutput("plan_div0_clear", 64'(bus.err_div0), 64'(0));
    applyStimulus(K_DIV, 32'hFFFF_FFFF, 32'h8000_0000, 6'd2, 1'b0, 2, 1'b0, got);
    checkOutput("plan_div_ovf", 64'({got, bus.err_ovf}), 64'({32'h8000_0000, 1'b1}));
    applyStimulus(K_ADD, 32'd1, 32'd2, 6'd1, 1'b0, 1, 1'b0, got);
    checkOutput("plan_under", 64'(bus.err_under), 64'(1));
`ifdef HEX_ENTRY_EN
    applyStimulus(K9, 32'h1A, 32'd0, 6'd1, 1'b1, 1, 1'b0, got);
    checkOutput("plan_hex", 64'(got), 64'(32'h1A9));
    applyStimulus(K1, 32'hF000_0000, 32'd0, 6'd1, 1'b1, 1, 1'b0, got);
    checkOutput("plan_hex_ovf", 64'(bus.err_ovf), 64'(1));
`endif

    // Reset in the middle of a division aborts it without a pulse
    bus.key = K_DIV; bus.top = 32'd3; bus.next = 32'd100; bus.count = 6'd2;
    @(negedge clock);
    checkOutput("abort_busy", 64'(bus.busy), 64'(1));
    bus.key = 5'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_value = '0; m_ovf = 1'b0; m_under = 1'b0; m_div0 = 1'b0;
    checkOutput("abort_ctl", 64'({bus.busy, bus.write, bus.push, bus.pop}), 64'(4'b0000));
    checkOutput("abort_value", 64'(bus.value), 64'(0));
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus.write || bus.push || bus.pop) seen++;
    end
    checkOutput("abort_no_pulse", 64'(seen), 64'(0));

    for (int i = 0; i < 200; i++) begin
      code = {1'b1, 4'($urandom_range(0, 15))};
      cnt  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 1)) : 6'($urandom_range(2, 63));
`ifdef HEX_ENTRY_EN
      hx = 1'($urandom_range(0, 1));
`else
      hx = 1'b0;
`endif
      applyStimulus(code, pick_operand(), pick_operand(), cnt, hx,
                    $urandom_range(1, 4), 1'($urandom_range(0, 1)), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
